// File: rtl/regfile_2r1w_if.sv
// Bus bundle for regfile_2r1w: one synchronous write port, two combinational
// read ports and the dropped-write flag.
interface regfile_2r1w_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4
);
    logic              WE;
    logic [ADDR_W-1:0] WADDR;
    logic [WIDTH-1:0]  WDATA;
    logic [ADDR_W-1:0] RADDR_A;
    logic [ADDR_W-1:0] RADDR_B;
    logic [WIDTH-1:0]  RDATA_A;
    logic [WIDTH-1:0]  RDATA_B;
    logic              WR_ERR;

    modport master (
        output WE, WADDR, WDATA, RADDR_A, RADDR_B,
        input  RDATA_A, RDATA_B, WR_ERR
    );

    modport slave (
        input  WE, WADDR, WDATA, RADDR_A, RADDR_B,
        output RDATA_A, RDATA_B, WR_ERR
    );
endinterface

// File: rtl/regfile_2r1w.sv
// DEPTH x WIDTH register file, two combinational read ports and one write port,
// with optional hardwired-zero r0, write-to-read bypass and address range guard.
module regfile_2r1w #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic          CLK,
    input  logic          RST,
    regfile_2r1w_if.slave bus
);

    if (WIDTH < 1 || DEPTH < 2 || $clog2(DEPTH) > ADDR_W) begin : g_bad_cfg
        $error("regfile_2r1w: need WIDTH >= 1 and 2 <= DEPTH <= 2**ADDR_W");
    end

    localparam int unsigned DEPTH_U = DEPTH;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_err_q;
    logic             wr_err_d;
    logic             wr_valid;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < DEPTH_U;
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Priority: reset, out of range, hardwired zero, bypass, storage.
    function automatic logic [WIDTH-1:0] read_port(
        input logic [ADDR_W-1:0] ra,
        input logic              rst,
        input logic              wv,
        input logic [ADDR_W-1:0] wa,
        input logic [WIDTH-1:0]  wd,
        input logic [WIDTH-1:0]  m [DEPTH]
    );
        logic [WIDTH-1:0] v;
        v = '0;
        if (rst || !in_range(ra) || is_zero_reg(ra)) begin
            v = '0;
        end else if (BYPASS != 0 && wv && wa == ra) begin
            v = wd;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (32'(ra) == 32'(i)) v = m[i];
            end
        end
        return v;
    endfunction

    assign wr_valid = bus.WE && in_range(bus.WADDR) && !is_zero_reg(bus.WADDR);
    // A write to the hardwired zero register is silently ignored, not an error.
    assign wr_err_d = bus.WE && !in_range(bus.WADDR);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_err_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_valid && 32'(bus.WADDR) == 32'(i)) mem_q[i] <= bus.WDATA;
            end
        end
    end

    always_comb begin
        bus.RDATA_A = read_port(bus.RADDR_A, RST, wr_valid, bus.WADDR, bus.WDATA, mem_q);
        bus.RDATA_B = read_port(bus.RADDR_B, RST, wr_valid, bus.WADDR, bus.WDATA, mem_q);
    end

    assign bus.WR_ERR = wr_err_q;

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Parametrised multi-port register file: DEPTH words of WIDTH bits, with two independent read ports and one synchronous write port.
- Successor to the fixed 16x16-bit word-select mux used in the single-cycle datapath: read selection is generalised in width and depth, and the selected words now come from internal storage.
- Adds an optional hardwired-zero register 0, optional write-to-read bypass and out-of-range address protection.
- Sits between decode and the ALU; the two read ports feed operand A/B, and the write port is driven by writeback.

Parameters:
- WIDTH, 16, data word width in bits (>=1).
- DEPTH, 16, number of registers (2..2^ADDR_W).
- ADDR_W, 4, address width; 2^ADDR_W >= DEPTH is required and checked at elaboration.
- ZERO_REG, 1, 1 = register 0 reads 0 always and ignores writes; 0 = register 0 is ordinary.
- BYPASS, 1, 1 = a same-cycle write forwards WDATA to a matching read port; 0 = reads return the stored value.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous active-high reset.
- WE  input  1  write enable, sampled at the rising edge of CLK.
- WADDR  input  ADDR_W  write address.
- WDATA  input  WIDTH  write data.
- RADDR_A  input  ADDR_W  read address, port A.
- RADDR_B  input  ADDR_W  read address, port B.
- RDATA_A  output  WIDTH  read data, port A; combinational.
- RDATA_B  output  WIDTH  read data, port B; combinational.
- WR_ERR  output  1  registered; 1 for one cycle after a write attempt that was dropped.

Behaviour:
- Reset:
  - RST high clears all DEPTH registers and WR_ERR to 0 immediately, with no CLK edge needed.
  - While RST is held: RDATA_A = RDATA_B = 0, all writes are blocked, and BYPASS forwarding is suppressed.
  - Reset asserting mid-write: reset wins; the storage ends at 0.
- Write:
  - At the rising edge of CLK with RST low, WE=1 and a valid WADDR, mem[WADDR] <= WDATA.
  - Write latency is one edge; the new value is visible through storage from the cycle after the edge.
- Valid write address: WADDR < DEPTH, and additionally WADDR != 0 when ZERO_REG=1.
- Dropped write:
  - WE=1 with an invalid WADDR leaves the storage unchanged.
  - WR_ERR <= 1 at that edge; otherwise WR_ERR <= 0 at every edge. WR_ERR never sticks.
  - Writing register 0 with ZERO_REG=1 is dropped but is not an error: WR_ERR stays 0.
- Read:
  - Purely combinational; zero-cycle latency from RADDR_x to RDATA_x.
  - The two ports are fully independent and may use the same address.
- Read value priority, evaluated per port:
  1. RST high -> 0.
  2. RADDR_x >= DEPTH -> 0.
  3. ZERO_REG=1 and RADDR_x == 0 -> 0.
  4. BYPASS=1, WE=1, WADDR == RADDR_x and the write is valid -> WDATA.
  5. Otherwise -> mem[RADDR_x].
- Simultaneous events:
  - Both ports reading the register currently being written both receive WDATA when BYPASS=1.
  - With BYPASS=0 both receive the old value until after the edge.
- Width rule: no truncation or extension anywhere; WDATA and RDATA are exactly WIDTH bits.
- Non-power-of-2 DEPTH (e.g. 12 with ADDR_W=4): addresses 12..15 are out of range and follow the rules above.
- No X propagation: every read path resolves to a defined value for any address.

Test Plan:
1. Reset sweep: write 0xA5A5 to r5, pulse RST between clock edges -> RDATA on r5 is 0x0000 immediately; WR_ERR=0; all registers read 0 after release.
2. Write/read-back: write r1=0x1234 and r15=0xFFFF on consecutive edges, then read A=r1, B=r15 -> 0x1234 and 0xFFFF; reading the same address on both ports gives equal data.
3. Bypass: BYPASS=1, r3 holds 0x0001; drive WE=1, WADDR=3, WDATA=0xBEEF with RADDR_A=RADDR_B=3 -> both ports read 0xBEEF in the same cycle. Rerun with BYPASS=0 -> 0x0001 before the edge and 0xBEEF after.
4. Zero register: ZERO_REG=1, write 0x7777 to r0 -> r0 reads 0x0000 with WR_ERR=0. With ZERO_REG=0 the same write reads back 0x7777.
5. Out of range: DEPTH=12, ADDR_W=4; write to address 13 -> storage unchanged, WR_ERR=1 for exactly one cycle; reading address 14 returns 0x0000.
6. Parametric: WIDTH=32, DEPTH=32, ADDR_W=5; random writes and reads checked against a reference model for 10k cycles, including asynchronous resets injected at random points.
